// File: rtl/gcd_frac_reducer_if.sv
// gcd_frac_reducer_if: operand/result handshake bundle for gcd_frac_reducer.
//   in_valid/in_ready         operand triple handshake
//   in_num/in_den/in_gcd      numerator, denominator and their GCD
//   out_valid/out_ready       result handshake
//   out_num/out_den/out_err   reduced fraction and error flag
//   out_lcm/out_lcm_ovf       LCM low bits and overflow (zero unless LCM support is built in)
// Modports: master drives operands and out_ready; slave is the reducer.
interface gcd_frac_reducer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic [WIDTH-1:0] in_gcd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic [WIDTH-1:0] out_den;
    logic             out_err;
    logic [WIDTH-1:0] out_lcm;
    logic             out_lcm_ovf;

    modport master (
        output in_valid, in_num, in_den, in_gcd, out_ready,
        input  in_ready, out_valid, out_num, out_den, out_err, out_lcm, out_lcm_ovf
    );

    modport slave (
        input  in_valid, in_num, in_den, in_gcd, out_ready,
        output in_ready, out_valid, out_num, out_den, out_err, out_lcm, out_lcm_ovf
    );
endinterface

// File: rtl/gcd_frac_reducer.sv
// gcd_frac_reducer: divides a fraction (num, den) by its precomputed GCD with one shared
// multi-cycle restoring divider (both operands in parallel, MSB first, one bit per cycle)
// and returns the reduced fraction over a valid/ready handshake.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    gcd_frac_reducer_if.slave (operand triple in, reduced fraction out)
// Optional feature: define GCD_FRAC_LCM_EN to add a one-cycle MUL state computing
// out_lcm = (num/gcd)*den (low WIDTH bits) and out_lcm_ovf (truncation flag).
// Without it, out_lcm/out_lcm_ovf are tied to 0 and no multiplier exists.
module gcd_frac_reducer #(
    parameter int unsigned WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    gcd_frac_reducer_if.slave bus
);

    localparam int unsigned CntWidth = $clog2(WIDTH) + 1;
    localparam logic [CntWidth-1:0] LastStep = CntWidth'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDiv  = 2'd1,
`ifdef GCD_FRAC_LCM_EN
        StMul  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    gcd_q, gcd_d;
    // Dividend shift registers: operand bits leave at the MSB, quotient bits enter at the LSB,
    // so after WIDTH steps they hold the quotients.
    logic [WIDTH-1:0]    num_sh_q, num_sh_d;
    logic [WIDTH-1:0]    den_sh_q, den_sh_d;
    logic [WIDTH:0]      rem_num_q, rem_num_d;
    logic [WIDTH:0]      rem_den_q, rem_den_d;
    logic [WIDTH-1:0]    out_num_q, out_num_d;
    logic [WIDTH-1:0]    out_den_q, out_den_d;
    logic                out_err_q, out_err_d;

`ifdef GCD_FRAC_LCM_EN
    logic [WIDTH-1:0]    den_lat_q, den_lat_d;
    logic [WIDTH-1:0]    out_lcm_q, out_lcm_d;
    logic                out_ovf_q, out_ovf_d;
    logic [2*WIDTH-1:0]  prod;

    assign prod = {{WIDTH{1'b0}}, out_num_q} * {{WIDTH{1'b0}}, den_lat_q};
`endif

    // Trial subtraction for the current restoring step.
    logic [WIDTH:0] num_try, den_try;
    logic           num_fit, den_fit;

    always_comb begin
        num_try = {rem_num_q[WIDTH-1:0], num_sh_q[WIDTH-1]};
        den_try = {rem_den_q[WIDTH-1:0], den_sh_q[WIDTH-1]};
        num_fit = (num_try >= {1'b0, gcd_q});
        den_fit = (den_try >= {1'b0, gcd_q});
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcd_d     = gcd_q;
        num_sh_d  = num_sh_q;
        den_sh_d  = den_sh_q;
        rem_num_d = rem_num_q;
        rem_den_d = rem_den_q;
        out_num_d = out_num_q;
        out_den_d = out_den_q;
        out_err_d = out_err_q;
`ifdef GCD_FRAC_LCM_EN
        den_lat_d = den_lat_q;
        out_lcm_d = out_lcm_q;
        out_ovf_d = out_ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    gcd_d     = bus.in_gcd;
                    num_sh_d  = bus.in_num;
                    den_sh_d  = bus.in_den;
                    rem_num_d = '0;
                    rem_den_d = '0;
                    cnt_d     = '0;
`ifdef GCD_FRAC_LCM_EN
                    den_lat_d = bus.in_den;
                    out_lcm_d = '0;
                    out_ovf_d = 1'b0;
`endif
                    if (bus.in_gcd == '0) begin
                        // Division by zero: pass operands through and flag the error.
                        out_num_d = bus.in_num;
                        out_den_d = bus.in_den;
                        out_err_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end

            StDiv: begin
                rem_num_d = num_fit ? (num_try - {1'b0, gcd_q}) : num_try;
                rem_den_d = den_fit ? (den_try - {1'b0, gcd_q}) : den_try;
                num_sh_d  = {num_sh_q[WIDTH-2:0], num_fit};
                den_sh_d  = {den_sh_q[WIDTH-2:0], den_fit};
                cnt_d     = cnt_q + CntWidth'(1);
                if (cnt_q == LastStep) begin
                    out_num_d = num_sh_d;
                    out_den_d = den_sh_d;
                    out_err_d = (|rem_num_d) | (|rem_den_d);
`ifdef GCD_FRAC_LCM_EN
                    state_d   = StMul;
`else
                    state_d   = StDone;
`endif
                end
            end

`ifdef GCD_FRAC_LCM_EN
            StMul: begin
                out_lcm_d = prod[WIDTH-1:0];
                out_ovf_d = |prod[2*WIDTH-1:WIDTH];
                state_d   = StDone;
            end
`endif

            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gcd_q     <= '0;
            num_sh_q  <= '0;
            den_sh_q  <= '0;
            rem_num_q <= '0;
            rem_den_q <= '0;
            out_num_q <= '0;
            out_den_q <= '0;
            out_err_q <= 1'b0;
`ifdef GCD_FRAC_LCM_EN
            den_lat_q <= '0;
            out_lcm_q <= '0;
            out_ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcd_q     <= gcd_d;
            num_sh_q  <= num_sh_d;
            den_sh_q  <= den_sh_d;
            rem_num_q <= rem_num_d;
            rem_den_q <= rem_den_d;
            out_num_q <= out_num_d;
            out_den_q <= out_den_d;
            out_err_q <= out_err_d;
`ifdef GCD_FRAC_LCM_EN
            den_lat_q <= den_lat_d;
            out_lcm_q <= out_lcm_d;
            out_ovf_q <= out_ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_num   = out_num_q;
    assign bus.out_den   = out_den_q;
    assign bus.out_err   = out_err_q;
`ifdef GCD_FRAC_LCM_EN
    assign bus.out_lcm     = out_lcm_q;
    assign bus.out_lcm_ovf = out_ovf_q;
`else
    assign bus.out_lcm     = '0;
    assign bus.out_lcm_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_frac_reducer.sv
// tb_gcd_frac_reducer: scoreboard bench for gcd_frac_reducer. The driver pushes the expected
// result of every accepted triple (from a plain-arithmetic model) into a queue; an independent
// monitor pops and compares on each result handshake.
module tb_gcd_frac_reducer;

    localparam int unsigned W = 32;
`ifdef GCD_FRAC_LCM_EN
    localparam int unsigned Lat = W + 2;
`else
    localparam int unsigned Lat = W + 1;
`endif

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic         err;
        logic [W-1:0] lcm;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcd_frac_reducer_if #(.WIDTH(W)) bus ();

    gcd_frac_reducer #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d,
                                   input logic [W-1:0] g);
        exp_t        r;
        logic [63:0] p;
        if (g == 0) begin
            r.num = n;
            r.den = d;
            r.err = 1'b1;
            r.lcm = '0;
            r.ovf = 1'b0;
        end else begin
            r.num = n / g;
            r.den = d / g;
            r.err = ((n % g) != 0) || ((d % g) != 0);
            p     = 64'(n / g) * 64'(d);
`ifdef GCD_FRAC_LCM_EN
            r.lcm = p[31:0];
            r.ovf = (p[63:32] != 0);
`else
            r.lcm = (p == 64'd0) ? '0 : '0;
            r.ovf = 1'b0;
`endif
        end
        return r;
    endfunction

    // Monitor: compares every result handshake against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=num 0x%0h required=no result", bus.out_num);
            end else begin
                e = sb.pop_front();
                check("out_num", bus.out_num, e.num);
                check("out_den", bus.out_den, e.den);
                check("out_err", bus.out_err, e.err);
                check("out_lcm", bus.out_lcm, e.lcm);
                check("out_lcm_ovf", bus.out_lcm_ovf, e.ovf);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    // mode 0: out_ready low, 1: out_ready high, 2: random
    task automatic set_rdy(input int mode);
        if (mode == 0)      bus.out_ready = 1'b0;
        else if (mode == 1) bus.out_ready = 1'b1;
        else                bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Called right after the accepting edge: checks latency, then (mode != 0) drains.
    task automatic finish_txn(input logic [W-1:0] g, input int mode);
        int  k;
        bit  ok;
        ok = 1'b0;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            set_rdy(mode);
            if (k == 1) check("busy_in_ready", bus.in_ready, 0);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL latency_timeout actual=no out_valid required=out_valid");
            return;
        end
        check("latency", k, (g == 0) ? 1 : Lat);
        if (mode == 0) return;
        ok = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            set_rdy(mode);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] g,
                        input int mode);
        bit ok;
        ok = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            set_rdy(mode);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready 0 required=in_ready 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_num   = n;
        bus.in_den   = d;
        bus.in_gcd   = g;
        @(posedge clk);
        sb.push_back(model(n, d, g));
        #1;
        bus.in_valid = 1'b0;
        bus.in_num   = $urandom;
        bus.in_den   = $urandom;
        bus.in_gcd   = $urandom;
        finish_txn(g, mode);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_num"}, bus.out_num, 0);
        check({tag, "_out_den"}, bus.out_den, 0);
        check({tag, "_out_err"}, bus.out_err, 0);
        check({tag, "_out_lcm"}, bus.out_lcm, 0);
        check({tag, "_out_lcm_ovf"}, bus.out_lcm_ovf, 0);
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] n, d, g;
        bit           seen;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_num    = '0;
        bus.in_den    = '0;
        bus.in_gcd    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        send(32'd12, 32'd18, 32'd6, 1);
        send(32'd10, 32'd4, 32'd3, 1);
        send(32'd0, 32'd0, 32'd0, 1);
        send(32'd0, 32'd7, 32'd7, 1);

        // Backpressure: result held for 10 cycles while a new triple is offered.
        send(32'd12, 32'd18, 32'd6, 0);
        e = model(32'd12, 32'd18, 32'd6);
        bus.in_valid = 1'b1;
        bus.in_num   = 32'd50;
        bus.in_den   = 32'd20;
        bus.in_gcd   = 32'd10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_num", bus.out_num, e.num);
            check("hold_out_den", bus.out_den, e.den);
            check("hold_out_err", bus.out_err, e.err);
            check("hold_out_lcm", bus.out_lcm, e.lcm);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_in_ready", bus.in_ready, 1);
        check("post_hs_out_valid", bus.out_valid, 0);
        @(posedge clk);
        sb.push_back(model(32'd50, 32'd20, 32'd10));
        #1;
        bus.in_valid = 1'b0;
        finish_txn(32'd10, 1);

        // Reset in the middle of a division.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_num    = 32'd100;
        bus.in_den    = 32'd75;
        bus.in_gcd    = 32'd25;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_div");
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_valid_after_reset", seen, 0);
        send(32'd100, 32'd75, 32'd25, 1);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    n = $urandom;
                    d = $urandom;
                    g = '0;
                end
                1, 2, 3, 4, 5: begin
                    g = $urandom_range(1, 5000);
                    n = g * $urandom_range(0, 50000);
                    d = g * $urandom_range(1, 50000);
                end
                6, 7, 8: begin
                    n = $urandom;
                    d = $urandom;
                    g = $urandom_range(1, 200);
                end
                default: begin
                    n = $urandom;
                    d = $urandom;
                    g = $urandom;
                end
            endcase
            send(n, d, g, 2);
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
